// File: rtl/commit_trace_buffer.sv
// Commit trace FIFO between the core's registered commit stream and the host.
// Optional build macro TRACE_FILTER_EN stores only state-changing records.
module commit_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_req,
  output logic          cpu_en,
  input  logic          commit,
  input  logic [31:0]   commit_pc,
  input  logic [31:0]   commit_inst,
  input  logic          commit_halt,
  input  logic          commit_reg_we,
  input  logic [4:0]    commit_reg_wa,
  input  logic [31:0]   commit_reg_wd,
  input  logic          commit_dmem_we,
  input  logic [31:0]   commit_dmem_wa,
  input  logic [31:0]   commit_dmem_wd,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [31:0]   trace_pc,
  output logic [31:0]   trace_inst,
  output logic [31:0]   trace_reg_wd,
  output logic [31:0]   trace_dmem_wa,
  output logic [31:0]   trace_dmem_wd,
  output logic          trace_reg_we,
  output logic          trace_dmem_we,
  output logic          trace_halt,
  output logic [4:0]    trace_reg_wa,
  output logic [AW:0]   fill_level,
  output logic [31:0]   inst_count,
  output logic          overflow,
  output logic          done
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
    logic        reg_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;
    logic        dmem_we;
    logic [31:0] dmem_wa;
    logic [31:0] dmem_wd;
  } rec_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [AW:0] LvlFull = (AW+1)'(DEPTH);
  localparam logic [AW:0] LvlHi   = (AW+1)'(DEPTH - 2);

  state_t      state_q, state_d;
  rec_t        mem_q [DEPTH];
  rec_t        wr_rec, head;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] level_q;
  logic [31:0] cnt_q;
  logic        en_q, ovf_q;
  logic        capture, keep, push, pop, full, drop, wr;

  // Only records the core committed while it was enabled are real.
  assign capture = commit & en_q & (state_q == RUN);

`ifdef TRACE_FILTER_EN
  assign keep = (commit_reg_we & (commit_reg_wa != 5'd0))
              | commit_dmem_we | commit_halt;
  assign wr_rec.reg_we = commit_reg_we & (commit_reg_wa != 5'd0);
`else
  assign keep = 1'b1;
  assign wr_rec.reg_we = commit_reg_we;
`endif

  assign wr_rec.pc      = commit_pc;
  assign wr_rec.inst    = commit_inst;
  assign wr_rec.halt    = commit_halt;
  assign wr_rec.reg_wa  = commit_reg_wa;
  assign wr_rec.reg_wd  = commit_reg_wd;
  assign wr_rec.dmem_we = commit_dmem_we;
  assign wr_rec.dmem_wa = commit_dmem_wa;
  assign wr_rec.dmem_wd = commit_dmem_wd;

  assign push = capture & keep;
  assign trace_valid = (level_q != '0);
  assign pop  = trace_valid & trace_ready;
  assign full = (level_q == LvlFull);
  assign drop = push & full & ~pop;
  assign wr   = push & ~drop;

  // Threshold leaves room for the record already in the core's commit reg.
  assign cpu_en = (state_q == RUN) & run_req & (level_q <= LvlHi);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (capture & commit_halt) state_d = DRAIN;
      DRAIN: if ((level_q == '0) & ~push) state_d = DONE;
      DONE:  state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      en_q    <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= cpu_en;
      if (capture) cnt_q <= cnt_q + 32'd1;
      if (drop) ovf_q <= 1'b1;
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (wr & ~pop) level_q <= level_q + 1'b1;
      else if (~wr & pop) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= wr_rec;
  end

  assign head = trace_valid ? mem_q[rptr_q] : '0;

  assign trace_pc      = head.pc;
  assign trace_inst    = head.inst;
  assign trace_halt    = head.halt;
  assign trace_reg_we  = head.reg_we;
  assign trace_reg_wa  = head.reg_wa;
  assign trace_reg_wd  = head.reg_wd;
  assign trace_dmem_we = head.dmem_we;
  assign trace_dmem_wa = head.dmem_wa;
  assign trace_dmem_wd = head.dmem_wd;

  assign fill_level = level_q;
  assign inst_count = cnt_q;
  assign overflow   = ovf_q;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: core stand-in plus queue-based reference.
// Expected values come from a transaction-level model of the trace FIFO.
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
    logic        reg_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;
    logic        dmem_we;
    logic [31:0] dmem_wa;
    logic [31:0] dmem_wd;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run_req, cpu_en, commit, commit_halt;
  logic [31:0] commit_pc, commit_inst, commit_reg_wd;
  logic        commit_reg_we, commit_dmem_we;
  logic [4:0]  commit_reg_wa;
  logic [31:0] commit_dmem_wa, commit_dmem_wd;
  logic        trace_valid, trace_ready;
  logic [31:0] trace_pc, trace_inst, trace_reg_wd;
  logic [31:0] trace_dmem_wa, trace_dmem_wd;
  logic        trace_reg_we, trace_dmem_we, trace_halt;
  logic [4:0]  trace_reg_wa;
  logic [AW:0] fill_level;
  logic [31:0] inst_count;
  logic        overflow, done;

  commit_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .cpu_en(cpu_en),
    .commit(commit), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_halt(commit_halt), .commit_reg_we(commit_reg_we),
    .commit_reg_wa(commit_reg_wa), .commit_reg_wd(commit_reg_wd),
    .commit_dmem_we(commit_dmem_we), .commit_dmem_wa(commit_dmem_wa),
    .commit_dmem_wd(commit_dmem_wd),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_inst(trace_inst),
    .trace_reg_wd(trace_reg_wd), .trace_dmem_wa(trace_dmem_wa),
    .trace_dmem_wd(trace_dmem_wd), .trace_reg_we(trace_reg_we),
    .trace_dmem_we(trace_dmem_we), .trace_halt(trace_halt),
    .trace_reg_wa(trace_reg_wa), .fill_level(fill_level),
    .inst_count(inst_count), .overflow(overflow), .done(done)
  );

  int checks = 0;
  int errors = 0;

  rec_t prog[$];
  rec_t mq[$];
  int   m_state;
  bit   m_en_q, m_ovf;
  logic [31:0] m_cnt;
  int   obs_pops;
  rec_t obs_last;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(int kind, logic [31:0] pc);
    rec_t r;
    logic [4:0] rd;
    r = '0;
    r.pc = pc;
    rd = 5'($urandom_range(0, 31));
    case (kind)
      0: begin
        r.inst = {12'($urandom), 5'd0, 3'b000, rd, 7'b0010011};
        r.reg_we = 1'b1;
        r.reg_wa = rd;
        r.reg_wd = $urandom;
      end
      1: begin
        r.inst = {7'd0, 5'd6, 5'd2, 3'b010, 5'd8, 7'b0100011};
        r.dmem_we = 1'b1;
        r.dmem_wa = {$urandom, 2'b00} >> 2 << 2;
        r.dmem_wd = $urandom;
      end
      2: r.inst = {7'd0, 5'd1, 5'd2, 3'b000, 5'd8, 7'b1100011};
      default: begin
        r.inst = 32'h00100073;
        r.halt = 1'b1;
      end
    endcase
    return r;
  endfunction

  function automatic rec_t addi(logic [31:0] pc, logic [4:0] rd,
                                logic [11:0] imm);
    rec_t r;
    r = '0;
    r.pc = pc;
    r.inst = {imm, 5'd0, 3'b000, rd, 7'b0010011};
    r.reg_we = 1'b1;
    r.reg_wa = rd;
    r.reg_wd = {{20{imm[11]}}, imm};
    return r;
  endfunction

  function automatic rec_t cur_rec();
    rec_t r;
    r.pc = commit_pc;
    r.inst = commit_inst;
    r.halt = commit_halt;
    r.reg_we = commit_reg_we;
    r.reg_wa = commit_reg_wa;
    r.reg_wd = commit_reg_wd;
    r.dmem_we = commit_dmem_we;
    r.dmem_wa = commit_dmem_wa;
    r.dmem_wd = commit_dmem_wd;
    return r;
  endfunction

  function automatic rec_t dut_head();
    rec_t r;
    r.pc = trace_pc;
    r.inst = trace_inst;
    r.halt = trace_halt;
    r.reg_we = trace_reg_we;
    r.reg_wa = trace_reg_wa;
    r.reg_wd = trace_reg_wd;
    r.dmem_we = trace_dmem_we;
    r.dmem_wa = trace_dmem_wa;
    r.dmem_wd = trace_dmem_wd;
    return r;
  endfunction

  task automatic drive(rec_t r);
    commit_pc = r.pc;
    commit_inst = r.inst;
    commit_halt = r.halt;
    commit_reg_we = r.reg_we;
    commit_reg_wa = r.reg_wa;
    commit_reg_wd = r.reg_wd;
    commit_dmem_we = r.dmem_we;
    commit_dmem_wa = r.dmem_wa;
    commit_dmem_wd = r.dmem_wd;
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 0;
    m_en_q = 1'b0;
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask

  // Compare against the model, then advance the model across the edge.
  task automatic check_model();
    bit exp_en, pop, full, cap, keep, push;
    int sz0;
    rec_t r, h;
    exp_en = (m_state == 0) && run_req && (mq.size() <= DEPTH - 2);
    chk("cpu_en", 32'(cpu_en), 32'(exp_en));
    chk("trace_valid", 32'(trace_valid), 32'(mq.size() != 0));
    chk("fill_level", 32'(fill_level), 32'(mq.size()));
    chk("inst_count", inst_count, m_cnt);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("done", 32'(done), 32'(m_state == 2));
    if (mq.size() != 0) begin
      h = dut_head();
      chk("trace_pc", h.pc, mq[0].pc);
      chk("trace_inst", h.inst, mq[0].inst);
      chk("trace_flags", {24'd0, h.halt, h.reg_we, h.dmem_we, h.reg_wa},
          {24'd0, mq[0].halt, mq[0].reg_we, mq[0].dmem_we, mq[0].reg_wa});
      chk("trace_reg_wd", h.reg_wd, mq[0].reg_wd);
      chk("trace_dmem_wa", h.dmem_wa, mq[0].dmem_wa);
      chk("trace_dmem_wd", h.dmem_wd, mq[0].dmem_wd);
    end
    if (trace_valid && trace_ready) begin
      obs_pops++;
      obs_last = dut_head();
    end
    if (rst) begin
      model_reset();
      return;
    end
    sz0 = mq.size();
    pop = (sz0 != 0) && trace_ready;
    full = (sz0 == DEPTH);
    cap = commit && m_en_q && (m_state == 0);
    r = cur_rec();
`ifdef TRACE_FILTER_EN
    keep = (r.reg_we && r.reg_wa != 0) || r.dmem_we || r.halt;
    r.reg_we = r.reg_we && (r.reg_wa != 0);
`else
    keep = 1'b1;
`endif
    push = cap && keep;
    if (cap) m_cnt = m_cnt + 1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (full && !pop) m_ovf = 1'b1;
      else mq.push_back(r);
    end
    if (m_state == 0 && cap && r.halt) m_state = 1;
    else if (m_state == 1 && sz0 == 0 && !push) m_state = 2;
    m_en_q = exp_en;
  endtask

  // Core stand-in: commits the next program record when enabled,
  // and holds its commit register (commit stays 1) while stalled.
  task automatic cycle();
    bit en_s;
    @(negedge clk);
    check_model();
    en_s = cpu_en;
    @(posedge clk);
    #1;
    if (rst) commit = 1'b0;
    else if (en_s) begin
      if (prog.size() != 0) begin
        drive(prog.pop_front());
        commit = 1'b1;
      end else commit = 1'b0;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load_rand(int n, logic [31:0] pc0);
    for (int i = 0; i < n; i++)
      prog.push_back(mk($urandom_range(0, 2), pc0 + 32'(4 * i)));
  endtask

  int exp_pops;

  initial begin
    rst = 1'b1;
    run_req = 1'b0;
    trace_ready = 1'b0;
    commit = 1'b0;
    drive('0);
    obs_pops = 0;
    obs_last = '0;
    model_reset();

    // Reset and start
    run(2);
    rst = 1'b0;
    cycle();
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_count", inst_count, 32'd0);
    run_req = 1'b1;
    cycle();
    chk("run_en", 32'(cpu_en), 32'd1);

    // Streaming ten addi
    for (int i = 0; i < 10; i++)
      prog.push_back(addi(32'h00400000 + 32'(4 * i), 5'(i + 1), 12'(i)));
    trace_ready = 1'b1;
    obs_pops = 0;
    run(20);
    chk("stream_count", inst_count, 32'd10);
    chk("stream_pops", 32'(obs_pops), 32'd10);
    chk("stream_last_pc", obs_last.pc, 32'h00400024);
    chk("stream_ovf", 32'(overflow), 32'd0);

    // Backpressure to full
    trace_ready = 1'b0;
    load_rand(30, 32'h00400100);
    run(30);
    chk("bp_fill", 32'(fill_level), 32'd16);
    chk("bp_cpu_en", 32'(cpu_en), 32'd0);
    chk("bp_count", inst_count, 32'd26);
    chk("bp_ovf", 32'(overflow), 32'd0);
    trace_ready = 1'b1;
    run(50);
    chk("bp_drain_count", inst_count, 32'd40);
    chk("bp_drain_pops", 32'(obs_pops), 32'd40);

    // Random traffic with random ready and run permission
    load_rand(120, 32'h00401000);
    for (int i = 0; i < 250; i++) begin
      trace_ready = ($urandom_range(0, 3) != 0);
      run_req = ($urandom_range(0, 7) != 0);
      cycle();
    end
    run_req = 1'b1;
    trace_ready = 1'b1;
    run(60);
    chk("rand_fill", 32'(fill_level), 32'd0);

    // Mid-run reset at level 8
    trace_ready = 1'b0;
    load_rand(20, 32'h00402000);
    for (int i = 0; i < 40 && mq.size() < 8; i++) cycle();
    chk("mid_fill", 32'(fill_level), 32'd8);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    prog.delete();
    chk("mid_rst_fill", 32'(fill_level), 32'd0);
    chk("mid_rst_count", inst_count, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_valid", 32'(trace_valid), 32'd0);
    run(3);

    // addi x0 / sw / addi x5,x0,3 sequence
    trace_ready = 1'b1;
    obs_pops = 0;
    prog.push_back(addi(32'h00400000, 5'd0, 12'd0));
    prog.push_back(mk(1, 32'h00400004));
    prog.push_back(addi(32'h00400008, 5'd5, 12'd3));
    run(12);
`ifdef TRACE_FILTER_EN
    exp_pops = 2;
`else
    exp_pops = 3;
`endif
    chk("flt_count", inst_count, 32'd3);
    chk("flt_pops", 32'(obs_pops), 32'(exp_pops));
    chk("flt_last_wd", obs_last.reg_wd, 32'd3);
    chk("flt_last_wa", 32'(obs_last.reg_wa), 32'd5);

    // Halt with random ready
    for (int i = 0; i < 5; i++)
      prog.push_back(mk(0, 32'h00403000 + 32'(4 * i)));
    prog.push_back(mk(3, 32'h00403014));
    load_rand(3, 32'h00403018);
    for (int i = 0; i < 120 && !done; i++) begin
      trace_ready = $urandom_range(0, 1);
      cycle();
    end
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_last", 32'(obs_last.halt), 32'd1);
    chk("halt_cpu_en", 32'(cpu_en), 32'd0);
    chk("halt_count", inst_count, 32'd9);
    run(4);
    chk("halt_hold", 32'(done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the single-cycle CPU core and consumes its registered commit_* record stream.
- Buffers commit records in a FIFO and drains them to the host/debug side over a valid/ready handshake.
- Generates the CPU's global_en. It stalls the core when the buffer nears full and stops it permanently after a halt commit.

Parameters:
DEPTH, 16, FIFO entries; power of 2, >= 4
AW, 4, log2(DEPTH); pointer width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
run_req  in  1  host permission to run the core
cpu_en  out  1  drives CPU global_en
commit  in  1  CPU commit flag
commit_pc  in  32  committed PC
commit_inst  in  32  committed instruction
commit_halt  in  1  committed inst is ebreak (0x00100073)
commit_reg_we  in  1  register write enable
commit_reg_wa  in  5  register write address
commit_reg_wd  in  32  register write data
commit_dmem_we  in  1  store enable
commit_dmem_wa  in  32  store address
commit_dmem_wd  in  32  store data
trace_valid  out  1  head record available
trace_ready  in  1  host accepts head record
trace_pc, trace_inst, trace_reg_wd, trace_dmem_wa, trace_dmem_wd  out  32 each  head record fields
trace_reg_we, trace_dmem_we, trace_halt  out  1 each  head record flags
trace_reg_wa  out  5  head record register address
fill_level  out  AW+1  entries held
inst_count  out  32  records captured since reset
overflow  out  1  sticky: record dropped
done  out  1  halt seen and buffer drained

Behaviour:
- Reset: all outputs 0 the cycle after rst; FIFO empty; FSM = RUN; en_q = 0.
- The CPU holds commit=1 while stalled, so it can repeat a stale record.
  - en_q is cpu_en registered.
  - capture = commit & en_q; capture is the only push condition.
- cpu_en, combinational: (state==RUN) & run_req & (fill_level <= DEPTH-2).
  - The DEPTH-2 threshold covers the one record in flight from the core's commit register.
- Push: at the edge ending a capture cycle, all commit_* fields are written at the write pointer; inst_count += 1 (wraps at 2^32).
- Pop: trace_valid = (fill_level != 0). trace_* are combinational from the head entry. Pop occurs when trace_valid & trace_ready.
- Simultaneous push and pop:
  - Any level: both happen, fill_level unchanged.
  - Empty: no bypass; the record appears the next cycle.
- Full: push when full without a pop drops the record and sets overflow (sticky until rst); pointers are unchanged. Unreachable under correct gating; flags misuse.
- Pointers are AW bits and wrap modulo DEPTH. fill_level tracks 0..DEPTH.
- Data outputs are don't-care when trace_valid = 0 and must not be checked.
- FSM:
  - RUN -> DRAIN when a captured record has commit_halt = 1.
  - DRAIN -> DONE when fill_level == 0 and no push is pending.
  - DONE holds until rst.
  - cpu_en = 0 in DRAIN and DONE. done = 1 only in DONE. Pushes in DRAIN/DONE are impossible (en_q = 0 by then) and are ignored.
- run_req low: cpu_en low next evaluation, state unchanged, draining continues.
- rst mid-operation: FIFO contents discarded, counters and overflow cleared, FSM = RUN.

Optional Feature:
- Macro: TRACE_FILTER_EN.
- Defined:
  - A captured record is pushed only if (reg_we & reg_wa != 0) | dmem_we | halt.
  - Other captures increment inst_count but are not stored.
  - Stored records with reg_wa = 0 have trace_reg_we forced to 0.
- Undefined: every capture is pushed unmodified.

Test Plan:
1. Reset check: rst high 2 cycles -> cpu_en=0, trace_valid=0, fill_level=0, inst_count=0, done=0; raise run_req -> cpu_en=1 next cycle.
2. Streaming: trace_ready=1, core runs 10 addi from PC 0x00400000 -> 10 records in order, trace_pc 0x00400000..0x00400024 step 4, inst_count=10, overflow=0.
3. Backpressure: trace_ready=0, DEPTH=16 -> cpu_en falls once fill_level=15; fill_level settles at 16, never exceeds it; overflow=0; no duplicate record while commit stays 1. Raise trace_ready -> cpu_en returns once fill_level<=14.
4. Halt: inst 0x00100073 committed -> cpu_en=0 from next cycle; last popped record has trace_halt=1; done=1 the cycle after fill_level hits 0.
5. Mid-run reset: fill_level=8, assert rst -> next cycle fill_level=0, inst_count=0, done=0, state RUN.
6. With TRACE_FILTER_EN: sequence addi x0,x0,0; sw; addi x5,x0,3 -> inst_count=3, 2 records stored (sw, x5 write with trace_reg_wd=3).
